// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave memory with independent INCR burst read and write engines
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   S_AXI_AW*                    write address channel (ID, byte address, beats-1, valid/ready)
//   S_AXI_W*                     write data channel (data, byte strobes, last, valid/ready)
//   S_AXI_B*                     write response channel (ID, OKAY/SLVERR, valid/ready)
//   S_AXI_AR*                    read address channel (ID, byte address, beats-1, valid/ready)
//   S_AXI_R*                     read data channel (ID, data, resp, last, valid/ready)
// Storage is 2^MEM_ADDR_BITS words; word index = addr[MEM_ADDR_BITS+1:2], wrapping per beat.
module axi_mem_responder #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 27,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS      = 14
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int DEPTH  = 1 << MEM_ADDR_BITS;
    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    r_state_t r_state, r_state_nxt;
    w_state_t w_state, w_state_nxt;

    logic [C_S_AXI_ID_WIDTH-1:0]   r_id, w_id;
    logic [7:0]                    r_len, r_cnt, w_len, w_cnt;
    logic [MEM_ADDR_BITS-1:0]      r_idx, w_idx, ar_index, aw_index, rd_index;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data;
    logic                          w_err;
    logic                          ar_fire, r_fire, r_last, rd_en;
    logic                          aw_fire, w_fire, w_last_beat, b_fire;

    // Address bits outside the word index are ignored by design.
    logic unused_addr;
    assign unused_addr = ^{S_AXI_ARADDR, S_AXI_AWADDR};

    assign ar_index    = S_AXI_ARADDR[MEM_ADDR_BITS+1:2];
    assign aw_index    = S_AXI_AWADDR[MEM_ADDR_BITS+1:2];

    assign ar_fire     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_fire      = S_AXI_RVALID && S_AXI_RREADY;
    assign r_last      = (r_cnt == r_len);
    assign aw_fire     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire      = S_AXI_WVALID && S_AXI_WREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign b_fire      = S_AXI_BVALID && S_AXI_BREADY;

    // The next word is fetched on the same edge the current beat is accepted,
    // so RDATA is already valid for the following beat with no bubble.
    assign rd_en    = ar_fire || (r_fire && !r_last);
    assign rd_index = ar_fire ? ar_index : r_idx;

    // ---------------- state registers ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_state_nxt;
            w_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
            R_DATA:  if (r_fire && r_last) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
            W_DATA:  if (w_fire && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (b_fire) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Gated by ARESET so every output reads 0 while reset is held,
    // even though the idle states themselves advertise ready.
    always_comb begin
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RLAST   = 1'b0;
        S_AXI_RID     = '0;
        S_AXI_RDATA   = '0;
        S_AXI_RRESP   = 2'b00;
        if (!ARESET) begin
            S_AXI_ARREADY = (r_state == R_IDLE);
            S_AXI_RVALID  = (r_state == R_DATA);
            S_AXI_RLAST   = (r_state == R_DATA) && r_last;
            S_AXI_RID     = r_id;
            S_AXI_RDATA   = r_data;
        end
    end

    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BID     = '0;
        S_AXI_BRESP   = 2'b00;
        if (!ARESET) begin
            S_AXI_AWREADY = (w_state == W_IDLE);
            S_AXI_WREADY  = (w_state == W_DATA);
            S_AXI_BVALID  = (w_state == W_RESP);
            S_AXI_BID     = w_id;
            S_AXI_BRESP   = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
        end
    end

    // ---------------- read burst bookkeeping ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_id  <= '0;
            r_len <= 8'd0;
            r_cnt <= 8'd0;
            r_idx <= '0;
        end else if (ar_fire) begin
            r_id  <= S_AXI_ARID;
            r_len <= S_AXI_ARLEN;
            r_cnt <= 8'd0;
            r_idx <= ar_index + 1'b1;
        end else if (r_fire && !r_last) begin
            r_cnt <= r_cnt + 8'd1;
            r_idx <= r_idx + 1'b1;
        end
    end

    // ---------------- write burst bookkeeping ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_id  <= '0;
            w_len <= 8'd0;
            w_cnt <= 8'd0;
            w_idx <= '0;
            w_err <= 1'b0;
        end else if (aw_fire) begin
            w_id  <= S_AXI_AWID;
            w_len <= S_AXI_AWLEN;
            w_cnt <= 8'd0;
            w_idx <= aw_index;
            w_err <= 1'b0;
        end else if (w_fire) begin
            w_cnt <= w_cnt + 8'd1;
            w_idx <= w_idx + 1'b1;
            // Burst length comes from AWLEN; a misplaced WLAST only flags SLVERR.
            if (S_AXI_WLAST != w_last_beat) begin
                w_err <= 1'b1;
            end
        end
    end

    // ---------------- storage ----------------
    // No reset here: contents survive ARESET. A same-cycle read of the word
    // being written returns the pre-write value (read-before-write).
    always_ff @(posedge ACLK) begin
        if (w_fire) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            r_data <= mem[rd_index];
        end
    end

endmodule
